// File: rtl/aes_vector_sequencer.sv
// AES known-answer sequencer: walks plaintext/ciphertext pairs from a ROM, issues each plaintext
// to the core over valid/ready and scores the returned block onto a per-vector pass bitmap.
module aes_vector_sequencer #(
  parameter int unsigned NUM_VEC = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned LED_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              loop_en,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_pt,
  input  logic [DATA_W-1:0] rom_ct,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic [DATA_W-1:0] plain_out,
  input  logic              ct_valid,
  input  logic [DATA_W-1:0] cipher_in,
  output logic [LED_W-1:0]  led,
  output logic [7:0]        err_cnt,
  output logic              timeout_flag,
  output logic              proto_err,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StFetch   = 3'd1;
  localparam logic [2:0] StWaitRom = 3'd2;
  localparam logic [2:0] StIssue   = 3'd3;
  localparam logic [2:0] StWaitCt  = 3'd4;
  localparam logic [2:0] StCheck   = 3'd5;
  localparam logic [2:0] StDone    = 3'd6;

  localparam int unsigned          TimerW   = $clog2(TIMEOUT);
  localparam logic [TimerW-1:0]    TimerMax = TimerW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0]    LastIdx  = ADDR_W'(NUM_VEC - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] plain_q, plain_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [DATA_W-1:0] ct_q, ct_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              vec_to_q, vec_to_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [7:0]        err_q, err_d;
  logic              tflag_q, tflag_d;
  logic              perr_q, perr_d;
  logic              restart;
  logic              pass;

  assign rom_en       = (state_q == StFetch);
  assign rom_addr     = idx_q;
  assign pt_valid     = (state_q == StIssue);
  assign plain_out    = plain_q;
  assign led          = led_q;
  assign err_cnt      = err_q;
  assign timeout_flag = tflag_q;
  assign proto_err    = perr_q;
  assign busy         = (state_q != StIdle) && (state_q != StDone);
  assign done         = (state_q == StDone);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    plain_d  = plain_q;
    exp_d    = exp_q;
    ct_d     = ct_q;
    timer_d  = timer_q;
    vec_to_d = vec_to_q;
    led_d    = led_q;
    err_d    = err_q;
    tflag_d  = tflag_q;
    perr_d   = perr_q;
    restart  = 1'b0;
    pass     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) restart = 1'b1;
      end
      StFetch: begin
        state_d = StWaitRom;
      end
      StWaitRom: begin
        plain_d = rom_pt;
        exp_d   = rom_ct;
        state_d = StIssue;
      end
      StIssue: begin
        if (pt_ready) begin
          timer_d  = '0;
          vec_to_d = 1'b0;
          state_d  = StWaitCt;
        end
      end
      StWaitCt: begin
        // A response on the final timer cycle still counts.
        if (ct_valid) begin
          ct_d    = cipher_in;
          state_d = StCheck;
        end else if (timer_q == TimerMax) begin
          vec_to_d = 1'b1;
          tflag_d  = 1'b1;
          state_d  = StCheck;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StCheck: begin
        pass = (ct_q == exp_q) && !vec_to_q;
        for (int k = 0; k < int'(LED_W); k++) begin
          if (k == int'(idx_q)) led_d[k] = pass;
        end
        if (!pass && (err_q != 8'hff)) err_d = err_q + 8'd1;
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = StFetch;
        end
      end
      StDone: begin
        if (start || loop_en) restart = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (restart) begin
      led_d   = '0;
      err_d   = '0;
      tflag_d = 1'b0;
      perr_d  = 1'b0;
      idx_d   = '0;
      state_d = StFetch;
    end

    // Stray responses are flagged but never consumed.
    if (ct_valid && (state_q != StWaitCt)) perr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      plain_q  <= '0;
      exp_q    <= '0;
      ct_q     <= '0;
      timer_q  <= '0;
      vec_to_q <= 1'b0;
      led_q    <= '0;
      err_q    <= '0;
      tflag_q  <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      plain_q  <= plain_d;
      exp_q    <= exp_d;
      ct_q     <= ct_d;
      timer_q  <= timer_d;
      vec_to_q <= vec_to_d;
      led_q    <= led_d;
      err_q    <= err_d;
      tflag_q  <= tflag_d;
      perr_q   <= perr_d;
    end
  end

endmodule

// File: tb/tb_aes_vector_sequencer.sv
// Bench for aes_vector_sequencer: a 16-vector instance driven by a behavioural core/ROM model and
// a single-vector instance checked against hand-computed timing.
module tb_aes_vector_sequencer;

  localparam int NV = 16;
  localparam int AW = 4;
  localparam int DW = 128;
  localparam int TO = 64;
  localparam int LW = 16;
  localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0;
  logic          rst, start, loop_en;
  logic          rom_en, pt_valid, pt_ready, ct_valid;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_pt, rom_ct, plain_out, cipher_in;
  logic [LW-1:0] led;
  logic [7:0]    err_cnt;
  logic          timeout_flag, proto_err, busy, done;

  logic          one_start, one_loop_en, one_rom_en, one_pt_valid, one_pt_ready, one_ct_valid;
  logic [0:0]    one_rom_addr;
  logic [DW-1:0] one_rom_pt, one_rom_ct, one_plain_out, one_cipher_in;
  logic [LW-1:0] one_led;
  logic [7:0]    one_err_cnt;
  logic          one_timeout_flag, one_proto_err, one_busy, one_done;

  int n_checks = 0;
  int n_err    = 0;

  // Stimulus configuration, written by the main sequence only.
  int corrupt_vec = -1;
  int silent_vec  = -1;
  int stall_vec   = -1;
  int stall_len   = 0;
  int resp_delay  = 3;
  int spur_req    = 0;

  // Model state, written by the core/monitor process only.
  int            spur_ack = 0;
  int            cyc = 0;
  int            xfer_idx = 0;
  int            fetch_idx = 0;
  int            total_xfers = 0;
  int            done_rises = 0;
  int            xfer_time [NV];
  int            stall_used = 0;
  logic [LW-1:0] exp_led = '0;
  int            exp_err = 0;
  logic          exp_to = 1'b0;
  logic          pend = 1'b0;
  int            pend_cnt = 0;
  logic [DW-1:0] pend_data = '0;
  logic          pv_prev = 1'b0, pr_prev = 1'b0, done_prev = 1'b0;
  logic [DW-1:0] plain_prev = '0;

  always #5 clk = ~clk;

  aes_vector_sequencer #(
    .NUM_VEC(NV), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .LED_W(LW)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .loop_en(loop_en),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_pt(rom_pt), .rom_ct(rom_ct),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .plain_out(plain_out),
    .ct_valid(ct_valid), .cipher_in(cipher_in),
    .led(led), .err_cnt(err_cnt), .timeout_flag(timeout_flag), .proto_err(proto_err),
    .busy(busy), .done(done)
  );

  aes_vector_sequencer #(
    .NUM_VEC(1), .ADDR_W(1), .DATA_W(DW), .TIMEOUT(TO), .LED_W(LW)
  ) u_one (
    .clk(clk), .rst(rst), .start(one_start), .loop_en(one_loop_en),
    .rom_en(one_rom_en), .rom_addr(one_rom_addr), .rom_pt(one_rom_pt), .rom_ct(one_rom_ct),
    .pt_valid(one_pt_valid), .pt_ready(one_pt_ready), .plain_out(one_plain_out),
    .ct_valid(one_ct_valid), .cipher_in(one_cipher_in),
    .led(one_led), .err_cnt(one_err_cnt), .timeout_flag(one_timeout_flag),
    .proto_err(one_proto_err), .busy(one_busy), .done(one_done)
  );

  function automatic logic [127:0] vec_pt(input int k);
    logic [31:0] w;
    if (k == 0) return PT0;
    w = 32'h9e37_79b9 * 32'(k + 1);
    return {w, ~w, w ^ 32'(k), w[15:0], w[31:16]};
  endfunction

  function automatic logic [127:0] vec_ct(input int k);
    logic [127:0] p;
    if (k == 0) return CT0;
    p = vec_pt(k);
    return {p[63:0], p[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Registered ROMs: data appears the cycle after the read strobe.
  initial begin
    forever begin
      @(posedge clk);
      if (rom_en) begin
        rom_pt <= vec_pt(int'(rom_addr));
        rom_ct <= vec_ct(int'(rom_addr));
      end
      if (one_rom_en) begin
        one_rom_pt <= PT0;
        one_rom_ct <= CT0;
      end
    end
  end

  // AES core stand-in plus per-cycle monitor and pass-level scoreboard for u_dut.
  initial begin
    int  v;
    logic ok;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend = 1'b0; xfer_idx = 0; fetch_idx = 0; stall_used = 0;
        exp_led = '0; exp_err = 0; exp_to = 1'b0;
        ct_valid = 1'b0; pt_ready = 1'b1;
        pv_prev = 1'b0; pr_prev = 1'b0; done_prev = 1'b0;
      end else begin
        if (rom_en) begin
          check("rom_addr", 128'(rom_addr), 128'(fetch_idx));
          fetch_idx = (fetch_idx + 1) % NV;
        end
        if (pv_prev && !pr_prev) begin
          check("pt_valid_hold", 128'(pt_valid), 128'(1));
          check("plain_stable", plain_out, plain_prev);
        end
        if (pt_valid) check("plain_out", plain_out, vec_pt(xfer_idx));
        if (done && !done_prev) begin
          done_rises++;
          check("led_model", 128'(led), 128'(exp_led));
          check("err_model", 128'(err_cnt), 128'(exp_err));
          check("timeout_model", 128'(timeout_flag), 128'(exp_to));
        end

        ct_valid = 1'b0;
        if (pend) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            ct_valid = 1'b1; cipher_in = pend_data; pend = 1'b0;
          end
        end
        if (pv_prev && pr_prev) begin
          v = xfer_idx;
          xfer_time[v] = cyc;
          total_xfers++;
          if (v == 0) begin exp_led = '0; exp_err = 0; exp_to = 1'b0; end
          ok = (v != corrupt_vec) && (v != silent_vec);
          if (ok && v < LW) exp_led[v] = 1'b1;
          if (!ok) exp_err++;
          if (v == silent_vec) begin
            exp_to = 1'b1;
          end else begin
            pend = 1'b1;
            pend_cnt = resp_delay - 1;
            pend_data = vec_ct(v) ^ ((v == corrupt_vec) ? 128'd1 : 128'd0);
          end
          xfer_idx = (v + 1) % NV;
          stall_used = 0;
        end
        if (spur_req != spur_ack) begin
          ct_valid = 1'b1; cipher_in = '1; spur_ack++;
        end
        if (pt_valid && xfer_idx == stall_vec && stall_used < stall_len) begin
          pt_ready = 1'b0; stall_used++;
        end else begin
          pt_ready = 1'b1;
        end
        pv_prev = pt_valid; pr_prev = pt_ready; plain_prev = plain_out; done_prev = done;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string name);
    int n = 0;
    while (!done && n < maxc) begin @(negedge clk); n++; end
    check(name, 128'(done), 128'(1));
  endtask

  initial begin
    int base, n, done_k, xfer_k, r0;
    logic prev_pv;
    rst = 1'b1; start = 1'b0; loop_en = 1'b0;
    one_start = 1'b0; one_loop_en = 1'b0; one_pt_ready = 1'b1;
    one_ct_valid = 1'b0; one_cipher_in = '0;
    repeat (3) @(negedge clk);
    check("rst_led", 128'(led), 128'(0));
    check("rst_flags", 128'({err_cnt, timeout_flag, proto_err, busy, done, pt_valid, rom_en}),
          128'(0));
    check("rst_plain", plain_out, 128'(0));
    rst = 1'b0;

    // Single vector: 15 cycles from the start cycle to done.
    @(negedge clk); one_start = 1'b1;
    done_k = -1; xfer_k = -1; prev_pv = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      one_start = 1'b0;
      if (k == 1) check("one_rom_fetch", 128'({one_rom_en, one_rom_addr}), 128'(2'b10));
      if (one_pt_valid) check("one_plain", one_plain_out, PT0);
      if (xfer_k < 0 && prev_pv) xfer_k = k;
      one_ct_valid = (xfer_k >= 0) && (k == xfer_k + 9);
      one_cipher_in = CT0;
      if (one_done && done_k < 0) done_k = k;
      prev_pv = one_pt_valid;
    end
    check("one_latency", 128'(done_k), 128'(15));
    check("one_led", 128'(one_led), 128'(16'h0001));
    check("one_err", 128'({one_err_cnt, one_timeout_flag, one_proto_err}), 128'(0));

    // Stray response while idle.
    @(negedge clk); spur_req++;
    repeat (3) @(negedge clk);
    check("spur_proto", 128'(proto_err), 128'(1));
    check("spur_idle", 128'({busy, done, led}), 128'(0));

    // Corrupted vector 5, 7 cycles of backpressure on vector 1.
    corrupt_vec = 5; stall_vec = 1; stall_len = 7; base = total_xfers;
    pulse_start();
    check("start_clears_proto", 128'(proto_err), 128'(0));
    wait_done(2000, "done_corrupt");
    check("corrupt_led", 128'(led), 128'(16'hFFDF));
    check("corrupt_err", 128'(err_cnt), 128'(1));
    check("corrupt_to", 128'(timeout_flag), 128'(0));
    check("corrupt_xfers", 128'(total_xfers - base), 128'(16));
    check("stall_gap", 128'(xfer_time[1] - xfer_time[0]), 128'(14));
    check("normal_gap", 128'(xfer_time[3] - xfer_time[2]), 128'(7));

    // Silent core on vector 2.
    corrupt_vec = -1; stall_vec = -1; silent_vec = 2;
    pulse_start();
    wait_done(3000, "done_timeout");
    check("to_flag", 128'(timeout_flag), 128'(1));
    check("to_led", 128'(led), 128'(16'hFFFB));
    check("to_err", 128'(err_cnt), 128'(1));
    check("to_gap", 128'(xfer_time[3] - xfer_time[2]), 128'(68));

    // Reset while waiting on vector 3's ciphertext.
    silent_vec = -1; base = total_xfers;
    pulse_start();
    n = 0;
    while (total_xfers < base + 4 && n < 500) begin @(negedge clk); n++; end
    check("reach_vec3", 128'(total_xfers - base), 128'(4));
    check("pre_rst_led", 128'(led), 128'(16'h0007));
    #2 rst = 1'b1;
    #1;
    check("async_rst_led", 128'(led), 128'(0));
    check("async_rst_ctl", 128'({busy, done, pt_valid, rom_en, rom_addr}), 128'(0));
    check("async_rst_plain", plain_out, 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = total_xfers;
    pulse_start();
    wait_done(2000, "done_after_rst");
    check("rerun_led", 128'(led), 128'(16'hFFFF));
    check("rerun_xfers", 128'(total_xfers - base), 128'(16));

    // Auto-restart: two passes, errors counted afresh each pass.
    corrupt_vec = 9; loop_en = 1'b1; r0 = done_rises;
    pulse_start();
    wait_done(2000, "loop_done1");
    n = 0;
    while (done && n < 5) begin @(negedge clk); n++; end
    check("loop_restart", 128'(done), 128'(0));
    wait_done(2000, "loop_done2");
    loop_en = 1'b0;
    check("loop_err", 128'(err_cnt), 128'(1));
    check("loop_led", 128'(led), 128'(16'hFDFF));
    repeat (3) @(negedge clk);
    check("loop_hold", 128'({done, busy}), 128'(2'b10));
    check("loop_rises", 128'(done_rises - r0), 128'(2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
